// File: rtl/serial_pattern_tx.sv
// Bit-serial pattern transmitter: NUM_PAT run-time writable patterns sent MSB-first
// with programmable length, bit period, repeat count and data inversion.
module serial_pattern_tx #(
    parameter int   PAT_LEN_MAX = 128,
    parameter int   NUM_PAT     = 4,
    parameter int   SEL_W       = 2,
    parameter int   LEN_W       = 8,
    parameter int   ADDR_W      = 4,
    parameter int   DIV_W       = 8,
    parameter int   REP_W       = 4,
    parameter logic IDLE_LVL    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [SEL_W-1:0]  cfg_sel,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [7:0]        cfg_wdata,
    output logic              cfg_err,
    input  logic              start,
    input  logic [SEL_W-1:0]  sel,
    input  logic [LEN_W-1:0]  len,
    input  logic [DIV_W-1:0]  div,
    input  logic [REP_W-1:0]  rep,
    input  logic              inv,
    input  logic              abort,
    output logic              tx,
    output logic              bit_stb,
    output logic              busy,
    output logic              eoc
);

    localparam int               IDX_W   = $clog2(PAT_LEN_MAX);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_LEN_MAX);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state_q, state_d;

    logic [PAT_LEN_MAX-1:0] pat_q [NUM_PAT];
    logic [PAT_LEN_MAX-1:0] pat_d [NUM_PAT];

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             inv_q, inv_d;

    logic [LEN_W-1:0] idx_q, idx_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

    logic eoc_q, eoc_d;
    logic cfg_err_q, cfg_err_d;

    logic             cfg_accept;
    logic [IDX_W-1:0] byte_base;
    logic [LEN_W-1:0] len_eff;
    logic [IDX_W-1:0] bit_idx;

    assign busy     = (state_q == SHIFT);
    assign byte_base = IDX_W'({cfg_addr, 3'b000});
    assign len_eff  = (len > LEN_MAX) ? LEN_MAX : len;
    assign bit_idx  = idx_q[IDX_W-1:0];

    // The pattern being shifted out is frozen; writes to any other slot proceed.
    assign cfg_accept = cfg_we && (!busy || (cfg_sel != sel_q));

    always_comb begin
        pat_d     = pat_q;
        cfg_err_d = 1'b0;
        if (cfg_accept) begin
            pat_d[cfg_sel][byte_base +: 8] = cfg_wdata;
        end else if (cfg_we) begin
            cfg_err_d = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        len_d     = len_q;
        div_d     = div_q;
        inv_d     = inv_q;
        idx_d     = idx_q;
        div_cnt_d = div_cnt_q;
        rep_cnt_d = rep_cnt_q;
        eoc_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    sel_d     = sel;
                    len_d     = len_eff;
                    div_d     = div;
                    inv_d     = inv;
                    rep_cnt_d = rep;
                    div_cnt_d = '0;
                    if (len_eff == '0) begin
                        eoc_d = 1'b1;
                    end else begin
                        idx_d   = len_eff - 1'b1;
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (div_cnt_q == div_q) begin
                    div_cnt_d = '0;
                    // Last clock of a bit: step down, rewind for a repeat, or finish.
                    if (idx_q != '0) begin
                        idx_d = idx_q - 1'b1;
                    end else if (rep_cnt_q != '0) begin
                        rep_cnt_d = rep_cnt_q - 1'b1;
                        idx_d     = len_q - 1'b1;
                    end else begin
                        state_d = IDLE;
                        eoc_d   = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PAT; i++) begin
                pat_q[i] <= '0;
            end
            cfg_err_q <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            len_q     <= '0;
            div_q     <= '0;
            inv_q     <= 1'b0;
            idx_q     <= '0;
            div_cnt_q <= '0;
            rep_cnt_q <= '0;
            eoc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            len_q     <= len_d;
            div_q     <= div_d;
            inv_q     <= inv_d;
            idx_q     <= idx_d;
            div_cnt_q <= div_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            eoc_q     <= eoc_d;
        end
    end

    assign tx      = busy ? (pat_q[sel_q][bit_idx] ^ inv_q) : IDLE_LVL;
    assign bit_stb = busy && (div_cnt_q == '0);
    assign eoc     = eoc_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: a scoreboard of expected {tx, bit_stb}
// per busy clock is filled when a send starts and drained by a negedge monitor.
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_sel = '0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic       cfg_err;
    logic       start = 1'b0;
    logic [1:0] sel = '0;
    logic [7:0] len = '0;
    logic [7:0] div = '0;
    logic [3:0] rep = '0;
    logic       inv = 1'b0;
    logic       abort = 1'b0;
    logic       tx;
    logic       bit_stb;
    logic       busy;
    logic       eoc;

    int checks = 0;
    int errors = 0;
    int eoc_count = 0;
    int stb_count = 0;
    int busy_cycles = 0;

    logic [1:0]   sb [$];
    logic [1:0]   exp_v;
    logic [127:0] model_pat [4];

    serial_pattern_tx dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_err(cfg_err),
        .start(start), .sel(sel), .len(len), .div(div), .rep(rep), .inv(inv),
        .abort(abort),
        .tx(tx), .bit_stb(bit_stb), .busy(busy), .eoc(eoc)
    );

    always #5 clk = ~clk;

    // Drain one scoreboard entry per busy clock; when idle the line must sit high.
    always @(negedge clk) begin
        if (rst) begin
            if (busy === 1'b1) begin
                busy_cycles = busy_cycles + 1;
                checks = checks + 1;
                if (sb.size() == 0) begin
                    errors = errors + 1;
                    $display("[TB] FAIL tx_unexpected: busy with empty scoreboard at %0t", $time);
                end else begin
                    exp_v = sb.pop_front();
                    if ({tx, bit_stb} !== exp_v) begin
                        errors = errors + 1;
                        $display("[TB] FAIL tx_bit: got tx/stb %b%b expected %b%b at %0t",
                                 tx, bit_stb, exp_v[1], exp_v[0], $time);
                    end
                end
            end else begin
                checks = checks + 1;
                if (tx !== 1'b1 || bit_stb !== 1'b0) begin
                    errors = errors + 1;
                    $display("[TB] FAIL idle_line: got tx/stb %b%b expected 10 at %0t", tx, bit_stb, $time);
                end
            end
            if (eoc === 1'b1) eoc_count = eoc_count + 1;
            if (bit_stb === 1'b1) stb_count = stb_count + 1;
        end
    end

    task automatic clear_counts();
        eoc_count = 0;
        stb_count = 0;
        busy_cycles = 0;
    endtask

    task automatic write_byte(input logic [1:0] s, input logic [3:0] a, input logic [7:0] d,
                              input bit upd_model);
        cfg_we = 1'b1;
        cfg_sel = s;
        cfg_addr = a;
        cfg_wdata = d;
        if (upd_model) model_pat[s][a*8 +: 8] = d;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic push_expected(input int s, input int l, input int d, input int r, input bit i);
        int eff;
        eff = (l > 128) ? 128 : l;
        for (int rr = 0; rr <= r; rr++)
            for (int b = eff - 1; b >= 0; b--)
                for (int c = 0; c <= d; c++)
                    sb.push_back({model_pat[s][b] ^ i, (c == 0) ? 1'b1 : 1'b0});
    endtask

    task automatic start_tx(input int s, input int l, input int d, input int r, input bit i);
        sel = 2'(s);
        len = 8'(l);
        div = 8'(d);
        rep = 4'(r);
        inv = i;
        push_expected(s, l, d, r, i);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_eoc(input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (eoc === 1'b1) got = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        bit got;
        repeat (2) @(negedge clk);
        checks = checks + 1;
        if ({tx, busy, eoc, bit_stb, cfg_err} !== 5'b10000) begin
            errors = errors + 1;
            $display("[TB] FAIL reset_outputs: got %b expected 10000", {tx, busy, eoc, bit_stb, cfg_err});
        end
        rst = 1'b1;
        @(posedge clk);
        #1 clear_counts();
        start_tx(2, 8, 0, 0, 0);
        wait_eoc(30, got);
        checks = checks + 1;
        if (!got || busy_cycles != 8) begin
            errors = errors + 1;
            $display("[TB] FAIL reset_pattern_send: got eoc %0d busy %0d expected 1 8", got, busy_cycles);
        end
    endtask

    task automatic test_basic();
        bit got;
        write_byte(0, 0, 8'hA5, 1);
        write_byte(0, 1, 8'h0F, 1);
        write_byte(0, 2, 8'h00, 1);
        write_byte(0, 3, 8'h81, 1);
        clear_counts();
        start_tx(0, 32, 0, 0, 0);
        wait_eoc(64, got);
        checks = checks + 1;
        if (!got || busy_cycles != 32 || stb_count != 32 || sb.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL basic_send: got eoc %0d busy %0d stb %0d left %0d expected 1 32 32 0",
                     got, busy_cycles, stb_count, sb.size());
        end
        @(negedge clk);
        checks = checks + 1;
        if (eoc !== 1'b0 || eoc_count != 1 || busy !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL basic_eoc_pulse: got eoc %b count %0d busy %b expected 0 1 0",
                     eoc, eoc_count, busy);
        end
    endtask

    task automatic test_repeat_inv();
        bit got;
        write_byte(1, 0, 8'h03, 1);
        clear_counts();
        start_tx(1, 2, 3, 2, 1);
        sel = 2'd0;
        len = 8'd5;
        div = 8'd0;
        rep = 4'd0;
        inv = 1'b0;
        wait_eoc(100, got);
        @(negedge clk);
        checks = checks + 1;
        if (!got || busy_cycles != 24 || stb_count != 6 || eoc_count != 1 || sb.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL repeat_inv: got eoc %0d busy %0d stb %0d eocs %0d expected 1 24 6 1",
                     got, busy_cycles, stb_count, eoc_count);
        end
    endtask

    task automatic test_len_zero();
        bit got;
        clear_counts();
        start_tx(0, 0, 0, 0, 0);
        wait_eoc(2, got);
        checks = checks + 1;
        if (!got) begin
            errors = errors + 1;
            $display("[TB] FAIL len_zero_eoc: got no eoc expected eoc next cycle");
        end
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (eoc_count != 1 || busy_cycles != 0 || tx !== 1'b1) begin
            errors = errors + 1;
            $display("[TB] FAIL len_zero_idle: got eocs %0d busy %0d tx %b expected 1 0 1",
                     eoc_count, busy_cycles, tx);
        end
    endtask

    task automatic test_clamp();
        bit got;
        for (int a = 0; a < 16; a++) write_byte(3, 4'(a), 8'($urandom_range(0, 255)), 1);
        clear_counts();
        start_tx(3, 200, 0, 0, 0);
        wait_eoc(300, got);
        checks = checks + 1;
        if (!got || busy_cycles != 128 || sb.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL len_clamp: got eoc %0d busy %0d expected 1 128", got, busy_cycles);
        end
    endtask

    task automatic test_abort();
        clear_counts();
        start_tx(0, 32, 0, 0, 0);
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checks = checks + 1;
        if (busy !== 1'b0 || tx !== 1'b1 || busy_cycles != 6) begin
            errors = errors + 1;
            $display("[TB] FAIL abort_stop: got busy %b tx %b bits %0d expected 0 1 6", busy, tx, busy_cycles);
        end
        sb.delete();
        repeat (4) @(negedge clk);
        checks = checks + 1;
        if (eoc_count != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL abort_no_eoc: got %0d eocs expected 0", eoc_count);
        end
        // Abort and start together in IDLE: nothing may happen.
        @(posedge clk);
        #1 clear_counts();
        len = 8'd8;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (busy_cycles != 0 || eoc_count != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL abort_priority: got busy %0d eocs %0d expected 0 0", busy_cycles, eoc_count);
        end
    endtask

    task automatic test_busy_cfg();
        bit got;
        write_byte(2, 0, 8'h5A, 1);
        write_byte(2, 1, 8'hC3, 1);
        clear_counts();
        start_tx(2, 16, 1, 0, 0);
        write_byte(2, 0, 8'hFF, 0);
        @(negedge clk);
        checks = checks + 1;
        if (cfg_err !== 1'b1) begin
            errors = errors + 1;
            $display("[TB] FAIL cfg_err_pulse: got %b expected 1", cfg_err);
        end
        @(negedge clk);
        checks = checks + 1;
        if (cfg_err !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL cfg_err_width: got %b expected 0", cfg_err);
        end
        write_byte(3, 1, 8'h77, 1);
        @(negedge clk);
        checks = checks + 1;
        if (cfg_err !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL cfg_other_accept: got cfg_err %b expected 0", cfg_err);
        end
        wait_eoc(64, got);
        checks = checks + 1;
        if (!got || busy_cycles != 32 || sb.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL busy_cfg_send: got eoc %0d busy %0d expected 1 32", got, busy_cycles);
        end
        clear_counts();
        start_tx(3, 16, 0, 0, 0);
        wait_eoc(40, got);
        checks = checks + 1;
        if (!got || busy_cycles != 16 || sb.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL cfg_other_send: got eoc %0d busy %0d expected 1 16", got, busy_cycles);
        end
    endtask

    task automatic test_write_start();
        bit got;
        clear_counts();
        cfg_we = 1'b1;
        cfg_sel = 2'd0;
        cfg_addr = 4'd0;
        cfg_wdata = 8'h3C;
        model_pat[0][7:0] = 8'h3C;
        start_tx(0, 8, 0, 0, 0);
        cfg_we = 1'b0;
        wait_eoc(30, got);
        checks = checks + 1;
        if (!got || busy_cycles != 8 || sb.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL write_with_start: got eoc %0d busy %0d expected 1 8", got, busy_cycles);
        end
    endtask

    task automatic test_back_to_back();
        bit got;
        clear_counts();
        push_expected(3, 16, 0, 0, 0);
        push_expected(3, 16, 0, 0, 0);
        sel = 2'd3;
        len = 8'd16;
        div = 8'd0;
        rep = 4'd0;
        inv = 1'b0;
        start = 1'b1;
        wait_eoc(40, got);
        checks = checks + 1;
        if (!got || busy !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL b2b_first: got eoc %0d busy %b expected 1 0", got, busy);
        end
        @(negedge clk);
        start = 1'b0;
        checks = checks + 1;
        if (busy !== 1'b1) begin
            errors = errors + 1;
            $display("[TB] FAIL b2b_restart: got busy %b expected 1", busy);
        end
        wait_eoc(40, got);
        checks = checks + 1;
        if (!got || busy_cycles != 32 || eoc_count != 2 || sb.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL b2b_total: got eoc %0d busy %0d eocs %0d expected 1 32 2",
                     got, busy_cycles, eoc_count);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        clear_counts();
        start_tx(0, 32, 0, 0, 0);
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks = checks + 1;
        if ({tx, busy, eoc, bit_stb, cfg_err} !== 5'b10000) begin
            errors = errors + 1;
            $display("[TB] FAIL reset_mid: got %b expected 10000", {tx, busy, eoc, bit_stb, cfg_err});
        end
        sb.delete();
        for (int p = 0; p < 4; p++) model_pat[p] = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 clear_counts();
        start_tx(0, 8, 0, 0, 0);
        wait_eoc(30, got);
        checks = checks + 1;
        if (!got || busy_cycles != 8 || sb.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL reset_clears_pat: got eoc %0d busy %0d expected 1 8", got, busy_cycles);
        end
    endtask

    initial begin
        for (int p = 0; p < 4; p++) model_pat[p] = '0;
        test_reset();
        test_basic();
        test_repeat_inv();
        test_len_zero();
        test_clamp();
        test_abort();
        test_busy_cfg();
        test_write_start();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
